// File: rtl/user_stream_seq_pkg.sv
// Shared types and constants for the OBI streamer job sequencer.
package user_stream_seq_pkg;

  // Default number of cycles allowed in WAIT/FLUSH before a job is failed.
  localparam int unsigned DefaultTimeoutCycles = 256;

  // Sequencer states; busy is simply "not IDLE".
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FLUSH = 3'd5
  } state_t;

endpackage

// File: rtl/user_stream_seq.sv
// Job sequencer for the OBI pixel streamer: issues one read per word at
// base + k*stride, buffers each returned word and hands it to the compute
// side over valid/ready. Adds word counting, timeout and abort with flush.

`ifndef FF
// Register with asynchronous active-low reset on clk_i/rst_ni.
`define FF(q_sig, d_sig, rst_val) \
  always_ff @(posedge clk_i or negedge rst_ni) begin \
    if (!rst_ni) q_sig <= (rst_val); \
    else         q_sig <= (d_sig); \
  end
`endif

module user_stream_seq
  import user_stream_seq_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // job control
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] stride_i,
  input  logic [CntWidth-1:0]  num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CntWidth-1:0]  words_done_o,
  // streamer side
  output logic                 strm_req_o,
  output logic                 strm_we_o,
  output logic [AddrWidth-1:0] strm_addr_o,
  input  logic [DataWidth-1:0] strm_rdata_i,
  input  logic                 strm_valid_i,
  // compute side
  output logic [DataWidth-1:0] pix_o,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i
);

  // The timeout counter only has to reach TimeoutCycles-1.
  localparam int unsigned TmoWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);

  state_t                 state_q,  state_d;
  logic [AddrWidth-1:0]   addr_q,   addr_d;
  logic [AddrWidth-1:0]   stride_q, stride_d;
  logic [CntWidth-1:0]    num_q,    num_d;
  logic [CntWidth-1:0]    words_q,  words_d;
  logic [TmoWidth-1:0]    tmo_q,    tmo_d;
  logic [DataWidth-1:0]   pix_q,    pix_d;
  logic                   err_q,    err_d;

  // Next-state and datapath updates for the job sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no branch can leave one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    num_d    = num_q;
    words_d  = words_q;
    tmo_d    = tmo_q;
    pix_d    = pix_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          stride_d = stride_i;
          num_d    = num_words_i;
          words_d  = '0;
          err_d    = 1'b0;
          state_d  = (num_words_i == '0) ? ST_DONE : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The request pulse is already out, so an abort must still flush it.
        tmo_d   = '0;
        state_d = abort_i ? ST_FLUSH : ST_WAIT;
      end

      ST_WAIT: begin
        if (abort_i && strm_valid_i) begin
          state_d = ST_IDLE;
        end else if (strm_valid_i) begin
          pix_d   = strm_rdata_i;
          words_d = words_q + CntWidth'(1);
          addr_d  = addr_q + stride_q;
          state_d = ST_HOLD;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d   = tmo_q + TmoWidth'(1);
          state_d = abort_i ? ST_FLUSH : ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (pix_ready_i) begin
          state_d = (words_q == num_q) ? ST_DONE : ST_ISSUE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_FLUSH: begin
        if (strm_valid_i) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value at the same edge regardless of statement order.
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Job registers: address, config, counters, pixel buffer and error flag.
  `FF(addr_q,   addr_d,   '0)
  `FF(stride_q, stride_d, '0)
  `FF(num_q,    num_d,    '0)
  `FF(words_q,  words_d,  '0)
  `FF(tmo_q,    tmo_d,    '0)
  `FF(pix_q,    pix_d,    '0)
  `FF(err_q,    err_d,    1'b0)

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;
  assign words_done_o = words_q;
  assign strm_req_o   = (state_q == ST_ISSUE);
  assign strm_we_o    = 1'b0;
  assign strm_addr_o  = addr_q;
  assign pix_o        = pix_q;
  assign pix_valid_o  = (state_q == ST_HOLD);

endmodule

// File: doc/user_stream_seq.md
Name: user_stream_seq

Overview:
Sequencer that drives the OBI pixel streamer through a multi-word read job of N words from base address B with byte stride S. It issues one streamer request at a time and waits for the matching response. Each returned word is buffered and handed to the compute side over a valid/ready stream. It sits between the user-domain config/control logic and user_obi_streamer, and adds job counting, timeout detection and abort with response flush.

Parameters:
AddrWidth, 32, width of OBI addresses, base and stride
DataWidth, 32, width of the pixel word (4 x 8-bit pixels)
CntWidth, 16, width of the word counter and num_words_i
TimeoutCycles, 256, maximum cycles spent in WAIT or FLUSH before an error is raised

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start job; sampled only in IDLE
abort_i  in  1  abort current job; ignored in IDLE
base_addr_i  in  AddrWidth  first word address; latched at start
stride_i  in  AddrWidth  address increment per word; latched at start
num_words_i  in  CntWidth  words in the job; latched at start
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when a job completes normally
err_o  out  1  sticky timeout flag; cleared by an accepted start_i
words_done_o  out  CntWidth  words handed to the consumer in the current job
strm_req_o  out  1  to streamer is_req_i; single-cycle pulse
strm_we_o  out  1  to streamer is_write_i; constant 0
strm_addr_o  out  AddrWidth  to streamer rw_addr_i
strm_rdata_i  in  DataWidth  from streamer rpixels_o
strm_valid_i  in  1  from streamer is_valid_o
pix_o  out  DataWidth  buffered pixel word
pix_valid_o  out  1  pix_o is valid
pix_ready_i  in  1  consumer accepts pix_o

Behaviour:
- Reset values: all outputs 0; state IDLE; all internal registers 0.
- States: IDLE, ISSUE, WAIT, HOLD, DONE, FLUSH.
- IDLE:
  - start_i=1 latches base, stride and num_words; clears err_o and words_done_o; sets the address register to base.
  - If num_words=0, go to DONE. Otherwise go to ISSUE.
- ISSUE: strm_req_o=1 for exactly one cycle, then go to WAIT. The timeout counter clears.
- strm_addr_o: driven from the address register and held stable from ISSUE until strm_valid_i returns. The streamer samples the address one cycle after the request.
- WAIT:
  - strm_valid_i=1 captures strm_rdata_i into the pix buffer, increments words_done_o, adds stride to the address (mod 2^AddrWidth, wrap silently) and goes to HOLD.
  - Otherwise the timeout counter increments. When it reaches TimeoutCycles-1, set err_o and go to IDLE with no done_o.
- HOLD: pix_valid_o=1 and pix_o is stable. On pix_ready_i=1:
  - if words_done_o==num_words, go to DONE;
  - else go to ISSUE.
- Per-word throughput: ISSUE (1 cycle) + streamer latency + HOLD (at least 1 cycle). No overlap; at most one request is outstanding.
- DONE: done_o=1 for one cycle, then go to IDLE. words_done_o holds its final value until the next start.
- abort_i:
  - In ISSUE, HOLD or DONE: go to IDLE next cycle; drop pix_valid_o; no done_o.
  - In ISSUE, the pulse already emitted counts as outstanding, so go to FLUSH instead of IDLE.
  - In WAIT: go to FLUSH.
- FLUSH: wait for strm_valid_i and discard the data, then go to IDLE. The timeout still applies: on expiry set err_o and go to IDLE.
- Simultaneous events:
  - abort_i together with strm_valid_i in WAIT: the response is discarded and the next state is IDLE.
  - abort_i together with pix_ready_i in HOLD: abort wins and no further request is issued.
- strm_valid_i is ignored in IDLE, HOLD and DONE. A stale response must not corrupt the buffer.
- start_i while busy_o=1 is ignored. Config inputs are not re-sampled while busy.
- Reset mid-job: immediate return to IDLE with all outputs 0. Streamer state is not the responsibility of this block.

Decomposition:
- Package user_stream_seq_pkg holds the state_t enum (3-bit) and the default timeout constant.
- No sub-module is needed. The timeout counter and word counter are inline registers using the `FF macro.

Test Plan:
- Basic job: base=0x1000_0000, stride=4, N=3, streamer model with 2-cycle response, pix_ready_i=1 -> addresses 0x1000_0000/04/08, three pix handshakes, words_done_o=3, a single done_o pulse, busy_o low afterwards.
- Backpressure: N=2, pix_ready_i held low for 10 cycles -> pix_o stable during the stall, second strm_req_o only after the first handshake.
- Zero length and wrap: N=0 -> done_o one cycle after start, no strm_req_o. Then base=0xFFFF_FFFC, stride=8, N=2 -> second address 0x0000_0004.
- Timeout: TimeoutCycles=16, streamer never responds -> err_o=1 after 16 WAIT cycles, no done_o, IDLE. The next start_i clears err_o.
- Abort with outstanding response: abort_i in WAIT, response arrives 3 cycles later -> data discarded, pix_valid_o stays 0, IDLE. A following job returns only fresh data.
- Start while busy: pulse start_i with a different base mid-job -> ignored, original address sequence continues.
